etai_share_arbiter: RTL and testbench
=====================================

Name: etai_share_arbiter

Overview:
- Shares one ETAI32 approximate adder among NREQ requesters using round-robin arbitration with valid/ready handshakes.
- Registers each result together with the exact sum, the absolute error and the requester ID.
- Keeps running error statistics (error-hit count, max AE) so approximation quality is tracked on-chip rather than only in post-processing.
- Sits between operand producers and the downstream consumer of approximate sums.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand width; fixed by ETAI32, any other value is unsupported and flagged by an elaboration check.
- CNTW, 16, width of the statistics counters.

Ports:
- Clk  input  1  clock, all state updates on posedge.
- Rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant/accept (one-hot or zero).
- req_a  input  NREQ*W  packed operand A; slice i belongs to requester i.
- req_b  input  NREQ*W  packed operand B.
- rsp_valid  output  1  result register holds a result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  clog2(NREQ)  requester index of the held result.
- rsp_sum  output  W+1  ETAI32 approximate sum.
- rsp_exact  output  W+1  exact unsigned sum A+B.
- rsp_abs_err  output  W+1  |rsp_sum - rsp_exact|.
- stat_clr  input  1  synchronous clear of the statistics.
- stat_err_cnt  output  CNTW  count of accepted results with nonzero error, saturating.
- stat_max_err  output  W+1  largest abs_err seen since clear.
- stat_total  output  CNTW  count of accepted results, saturating.

Behaviour:
- Reset values:
  - rsp_valid=0; rsp_id, rsp_sum, rsp_exact, rsp_abs_err all 0.
  - All statistics 0.
  - RR pointer=NREQ-1, so requester 0 has first priority.
  - FSM=EMPTY.
- FSM states:
  - EMPTY: result register free. On any req_valid, go to FULL.
  - FULL: result held. If rsp_ready and a new grant occur together, stay FULL with new data. If rsp_ready and no request, go to EMPTY.
- Grant condition: can_accept = (state==EMPTY) | rsp_ready.
- Grant selection: when can_accept, req_ready is one-hot on the first valid requester searching from ptr+1 upward, modulo NREQ.
  - Otherwise req_ready=0.
  - req_ready is combinational from req_valid, state and rsp_ready.
  - It never asserts for a requester whose req_valid is 0.
- Transfer: occurs when req_valid[i] & req_ready[i].
  - Operands of the granted slice are muxed into ETAI32 in the same cycle.
  - Result fields load on that posedge; rsp_valid=1 the next cycle.
  - Latency is 1 cycle; throughput is 1 per cycle while rsp_ready=1.
- Pointer: updates to the granted index only on a transfer; unchanged when idle or stalled.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all outputs hold stable and req_ready=0.
- Arithmetic:
  - exact = zero-extended A + B (W+1 bits).
  - abs_err is computed with a W+2-bit signed difference, then magnitude, then truncated to W+1 bits (the difference always fits).
- Statistics update on result acceptance (rsp_valid & rsp_ready), not on grant:
  - stat_total increments.
  - stat_err_cnt increments if abs_err != 0.
  - stat_max_err takes max(stat_max_err, abs_err).
  - Counters saturate at all-ones.
- stat_clr:
  - Has priority over a same-cycle update, so the value after a clear is 0 even if an acceptance occurs.
  - Does not affect the FSM.
- Reset mid-operation: a held result is discarded, with no statistics update; any pending requester must re-present its request.
- Requesters must hold req_valid and their operands until granted; the arbiter does not check this (the bench asserts it).

Decomposition:
- Package etai_share_pkg holds:
  - W_OP=32;
  - the FSM enum {EMPTY, FULL};
  - function abs_diff(W+1, W+1) -> W+1;
  - function rr_pick(valid vector, ptr) -> index plus found flag.
- Sub-module rr_arbiter (NREQ): pointer register plus combinational pick and grant.
- ETAI32 is instantiated unchanged as the shared datapath.

Test Plan:
- Single requester 0: A=1, B=2 -> req_ready[0] same cycle; next cycle rsp_valid=1, id=0, sum=3, exact=3, abs_err=0, stat_total=1 after accept.
- Error case: A=0x000000FF, B=0x00000001 -> exact=0x100, rsp_sum equal to the ETAI32 golden model (0x0FF with the 16-bit inaccurate part), abs_err=1, stat_err_cnt=1, stat_max_err=1.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,… with one result per cycle and rsp_id matching.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending -> req_ready=0, outputs stable, stats unchanged; on release, the next grant resumes from ptr+1.
- Counter saturation: preload via 65535 accepted error-producing results -> stat_err_cnt stays 0xFFFF; stat_clr asserted together with an acceptance -> all stats read 0.
- Rst asserted while FULL -> next cycle rsp_valid=0, ptr=NREQ-1, stats 0; first grant after reset goes to requester 0.

Source files
------------

// File: rtl/etai_share_pkg.sv
// Shared types and helpers for the ETAI32 sharing arbiter: operand width,
// result-register FSM states, absolute-difference and round-robin pick functions.
package etai_share_pkg;

    localparam int W_OP    = 32;
    localparam int MAX_REQ = 8;
    localparam int PICK_W  = 3;

    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // The W+2-bit signed difference always holds the full range of two W+1-bit sums.
    function automatic logic [W_OP:0] abs_diff(input logic [W_OP:0] x, input logic [W_OP:0] y);
        logic signed [W_OP+1:0] d;
        d = $signed({1'b0, x}) - $signed({1'b0, y});
        if (d < 0) d = -d;
        return d[W_OP:0];
    endfunction

    // First valid index after ptr, wrapping modulo nreq.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [PICK_W-1:0]  ptr,
                                      input int                 nreq);
        pick_t r;
        int    s;
        r = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            s = int'(ptr) + i;
            if (s >= nreq) s = s - nreq;
            if (i <= nreq && !r.found && valid[s[PICK_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = s[PICK_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/etai32.sv
// Error-tolerant adder type I: exact 16-bit upper half, carry-free lower half that
// saturates to ones from the highest position where both operand bits are set.
module etai32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [32:0] sum
);

    logic [15:0] lo;
    logic [16:0] hi;

    always_comb begin
        logic sat;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        sat = 1'b0;
        lo  = '0;
        for (int i = 15; i >= 0; i--) begin
            if (sat || (a[i] && b[i])) begin
                lo[i] = 1'b1;
                sat   = 1'b1;
            end else begin
                lo[i] = a[i] ^ b[i];
            end
        end
    end

    assign hi  = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign sum = {hi, lo};

endmodule

// File: rtl/etai_share_arbiter_rr_arbiter.sv
// Round-robin grant generator: pointer register plus combinational one-hot grant
// that searches from the last granted index upward.
module rr_arbiter
    import etai_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [NREQ-1:0] valid,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [IDW-1:0]     ptr;
    pick_t              pick;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        pick                  = rr_pick(valid_ext, PICK_W'(ptr), NREQ);
        grant                 = '0;
        if (enable && pick.found) grant[pick.idx[IDW-1:0]] = 1'b1;
    end

    assign grant_idx = pick.idx[IDW-1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Rst)         ptr <= IDW'(NREQ - 1);
        else if (|grant) ptr <= grant_idx;
    end

endmodule

// File: rtl/etai_share_arbiter.sv
// Shares one ETAI32 adder among NREQ requesters; registers approximate/exact sums,
// absolute error and requester ID, and tracks running error statistics.
module etai_share_arbiter
    import etai_share_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = 32,
    parameter  int CNTW = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W:0]        rsp_sum,
    output logic [W:0]        rsp_exact,
    output logic [W:0]        rsp_abs_err,
    input  logic              stat_clr,
    output logic [CNTW-1:0]   stat_err_cnt,
    output logic [W:0]        stat_max_err,
    output logic [CNTW-1:0]   stat_total
);

    if (W != W_OP) begin : g_bad_width
        $error("etai_share_arbiter: W must be 32 to match ETAI32");
    end
    if (NREQ < 2 || NREQ > MAX_REQ) begin : g_bad_nreq
        $error("etai_share_arbiter: NREQ must be in 2..8");
    end

    state_t         state, state_next;
    logic           can_accept, transfer, accept;
    logic [IDW-1:0] grant_idx;
    logic [W-1:0]   op_a, op_b;
    logic [W:0]     sum_approx, sum_exact, err;

    assign can_accept = (state == EMPTY) || rsp_ready;
    assign transfer   = |req_ready;
    assign rsp_valid  = (state == FULL);
    assign accept     = rsp_valid && rsp_ready;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .Clk       (Clk),
        .Rst       (Rst),
        .valid     (req_valid),
        .enable    (can_accept),
        .grant     (req_ready),
        .grant_idx (grant_idx)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                op_a = req_a[i*W +: W];
                op_b = req_b[i*W +: W];
            end
        end
    end

    etai32 u_etai (
        .a   (op_a),
        .b   (op_b),
        .sum (sum_approx)
    );

    assign sum_exact = {1'b0, op_a} + {1'b0, op_b};
    assign err       = abs_diff(sum_approx, sum_exact);

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (transfer) state_next = FULL;
            FULL:    if (rsp_ready && !transfer) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rsp_id      <= '0;
            rsp_sum     <= '0;
            rsp_exact   <= '0;
            rsp_abs_err <= '0;
        end else if (transfer) begin
            rsp_id      <= grant_idx;
            rsp_sum     <= sum_approx;
            rsp_exact   <= sum_exact;
            rsp_abs_err <= err;
        end
    end

    // Statistics follow consumer acceptance; a clear wins over a same-cycle update.
    always_ff @(posedge Clk) begin
        if (Rst || stat_clr) begin
            stat_total   <= '0;
            stat_err_cnt <= '0;
            stat_max_err <= '0;
        end else if (accept) begin
            if (stat_total != '1) stat_total <= stat_total + CNTW'(1);
            if (rsp_abs_err != '0 && stat_err_cnt != '1) stat_err_cnt <= stat_err_cnt + CNTW'(1);
            if (rsp_abs_err > stat_max_err) stat_max_err <= rsp_abs_err;
        end
    end

endmodule

// File: tb/tb_etai_share_arbiter.sv
// Randomized and directed bench for etai_share_arbiter against a transaction-level
// model of the arbitration, the ETA-I sum and the statistics.
module tb_etai_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int CNTW = 16;
    localparam int IDW  = 2;

    logic              Clk;
    logic              Rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W:0]        rsp_sum;
    logic [W:0]        rsp_exact;
    logic [W:0]        rsp_abs_err;
    logic              stat_clr;
    logic [CNTW-1:0]   stat_err_cnt;
    logic [W:0]        stat_max_err;
    logic [CNTW-1:0]   stat_total;

    etai_share_arbiter #(.NREQ(NREQ), .W(W), .CNTW(CNTW)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_exact    (rsp_exact),
        .rsp_abs_err  (rsp_abs_err),
        .stat_clr     (stat_clr),
        .stat_err_cnt (stat_err_cnt),
        .stat_max_err (stat_max_err),
        .stat_total   (stat_total)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ETA-I reference: upper half is a true 16-bit add; lower half is XOR, with all
    // bits at and below the highest both-ones position forced to one.
    function automatic logic [32:0] ref_etai(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] both, lo;
        logic [16:0] hi;
        int          p;
        both = a[15:0] & b[15:0];
        lo   = a[15:0] ^ b[15:0];
        p    = -1;
        for (int k = 0; k < 16; k++) if (both[k]) p = k;
        if (p >= 0) lo = lo | 16'((32'h1 << (p + 1)) - 1);
        hi = a[31:16] + b[31:16];
        return {hi, lo};
    endfunction

    // Stimulus: each requester holds valid and operands until granted.
    logic [NREQ-1:0] v;
    logic [31:0]     oa [NREQ];
    logic [31:0]     ob [NREQ];
    logic            rr, clr, rst_i;
    int              last_g;

    // Reference model state.
    bit          m_full;
    int          m_ptr, m_id;
    logic [32:0] m_sum, m_exact, m_err, m_max;
    int          m_total, m_errcnt;

    task automatic model_reset();
        m_full = 0; m_ptr = NREQ - 1; m_id = 0;
        m_sum = '0; m_exact = '0; m_err = '0; m_max = '0;
        m_total = 0; m_errcnt = 0;
    endtask

    task automatic step();
        int              g;
        logic [NREQ-1:0] eg;
        bit              acc;
        Rst       = rst_i;
        req_valid = v;
        rsp_ready = rr;
        stat_clr  = clr;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = oa[i];
            req_b[i*W +: W] = ob[i];
        end
        #3;
        g = -1;
        if (!m_full || rr) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        check("req_ready",    req_ready,    eg);
        check("rsp_valid",    rsp_valid,    m_full);
        check("rsp_id",       rsp_id,       m_id);
        check("rsp_sum",      rsp_sum,      m_sum);
        check("rsp_exact",    rsp_exact,    m_exact);
        check("rsp_abs_err",  rsp_abs_err,  m_err);
        check("stat_total",   stat_total,   m_total);
        check("stat_err_cnt", stat_err_cnt, m_errcnt);
        check("stat_max_err", stat_max_err, m_max);
        acc = m_full && rr;
        if (rst_i) begin
            model_reset();
        end else begin
            if (clr) begin
                m_total = 0; m_errcnt = 0; m_max = '0;
            end else if (acc) begin
                if (m_total < 65535) m_total++;
                if (m_err != 0 && m_errcnt < 65535) m_errcnt++;
                if (m_err > m_max) m_max = m_err;
            end
            if (g >= 0) begin
                logic [32:0] ex;
                ex      = {1'b0, oa[g]} + {1'b0, ob[g]};
                m_full  = 1;
                m_id    = g;
                m_ptr   = g;
                m_sum   = ref_etai(oa[g], ob[g]);
                m_exact = ex;
                m_err   = (m_sum > ex) ? m_sum - ex : ex - m_sum;
            end else if (acc) begin
                m_full = 0;
            end
        end
        @(posedge Clk);
        #1;
        if (!rst_i && g >= 0) v[g] = 1'b0;
        last_g = rst_i ? -1 : g;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 255));
            1:       return 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    task automatic raise(input int i, input logic [31:0] a, input logic [31:0] b);
        v[i] = 1'b1; oa[i] = a; ob[i] = b;
    endtask

    int expo;

    initial begin
        v = '0; rr = 1'b0; clr = 1'b0; rst_i = 1'b1; last_g = -1;
        for (int i = 0; i < NREQ; i++) begin oa[i] = '0; ob[i] = '0; end
        Rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; stat_clr = 1'b0;
        req_a = '0; req_b = '0;
        repeat (2) @(posedge Clk);
        #1;
        model_reset();
        rst_i = 1'b0;

        // Idle after reset: all outputs at reset values.
        step(); step();

        // Single requester 0: 1 + 2.
        rr = 1'b1;
        raise(0, 32'd1, 32'd2);
        step();
        check("t1_grant", last_g, 0);
        check("t1_valid", rsp_valid, 1);
        check("t1_sum",   rsp_sum, 33'd3);
        check("t1_exact", rsp_exact, 33'd3);
        check("t1_err",   rsp_abs_err, 0);
        step();
        check("t1_total", stat_total, 1);

        // Approximation error: 0xFF + 1.
        raise(0, 32'h0000_00FF, 32'h0000_0001);
        step();
        check("t2_sum",   rsp_sum, 33'h0FF);
        check("t2_exact", rsp_exact, 33'h100);
        check("t2_err",   rsp_abs_err, 1);
        step();
        check("t2_errcnt", stat_err_cnt, 1);
        check("t2_max",    stat_max_err, 1);

        // All requesters continuously valid: rotating grants, one per cycle.
        expo = 1;
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < NREQ; i++) if (!v[i]) raise(i, rand_op(), rand_op());
            step();
            check("rr_order", last_g, expo);
            expo = (expo + 1) % NREQ;
        end

        // Backpressure: no grants and stable outputs while the result is held.
        for (int i = 0; i < NREQ; i++) if (!v[i]) raise(i, rand_op(), rand_op());
        rr = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            check("bp_nogrant", last_g, -1);
        end
        rr = 1'b1;
        step();
        check("bp_resume", last_g, expo);

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!v[i] && $urandom_range(0, 2) == 0) raise(i, rand_op(), rand_op());
            rr    = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 49) == 0);
            rst_i = ($urandom_range(0, 199) == 0);
            step();
            rst_i = 1'b0; clr = 1'b0;
        end

        // Counter saturation with a stream of error-producing results.
        v = '0; rr = 1'b1; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int n = 0; n < 65540; n++) begin
            if (!v[0]) raise(0, 32'h0000_00FF, 32'h0000_0001);
            step();
        end
        check("sat_errcnt", stat_err_cnt, 16'hFFFF);
        check("sat_total",  stat_total,   16'hFFFF);
        check("sat_max",    stat_max_err, 1);
        check("sat_full",   rsp_valid,    1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_total",  stat_total,   0);
        check("clr_errcnt", stat_err_cnt, 0);
        check("clr_max",    stat_max_err, 0);

        // Reset while a result is held.
        v = '0; rr = 1'b0;
        raise(2, rand_op(), rand_op());
        step();
        check("rst_pre_full", rsp_valid, 1);
        for (int i = 0; i < NREQ; i++) if (!v[i]) raise(i, rand_op(), rand_op());
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst_valid", rsp_valid, 0);
        check("rst_total", stat_total, 0);
        rr = 1'b1;
        step();
        check("rst_first_grant", last_g, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
